// File: rtl/fall_pkg.sv
// ==== fall_pkg : shared types and constants for the fall-detection front end (rev 1.0) ====
`default_nettype none

package fall_pkg;

  localparam int FALL_DATA_W = 16;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/tick_sync_edge.sv
// ==== tick_sync_edge : synchroniser, armed qualifier and registered rising-edge pulse (rev 1.0) ====
`default_nettype none

module tick_sync_edge
  import fall_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   rise_q, rise_d;
  logic                   tick_s;

  assign tick_s = sync_q[SYNC_STAGES-1];

  // fill_q marks when tick_s carries a real post-reset sample, so the
  // reset-cleared chain cannot arm the detector on its own.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    prev_d  = tick_s;
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~tick_s);
    rise_d  = armed_q & tick_s & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

`default_nettype wire

// File: rtl/accel_sample_sequencer.sv
// ==== accel_sample_sequencer : tick-driven X/Y/Z read sequencer with overrun/timeout flags (rev 1.0) ====
`default_nettype none

module accel_sample_sequencer
  import fall_pkg::*;
#(
  parameter int DATA_W      = FALL_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_clk,
  input  logic              enable,
  output logic              rd_req,
  output logic [1:0]        rd_axis,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] z_out,
  output logic              sample_valid,
  output logic              overrun,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  sample_count
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic tick_rise;
  logic start;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .async_in(tick_clk),
    .rise    (tick_rise)
  );

  seq_state_t        state_q, state_d;
  logic [1:0]        axis_q, axis_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0] shx_q, shx_d, shy_q, shy_d, shz_q, shz_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign start = tick_rise & enable;

  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    to_cnt_d  = to_cnt_q;
    shx_d     = shx_q;
    shy_d     = shy_q;
    shz_d     = shz_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    overrun_d = start & (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          axis_d   = AXIS_X;
          to_cnt_d = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the final allowed cycle still counts as a good read.
        if (rd_ack) begin
          case (axis_q)
            AXIS_X:  shx_d = rd_data;
            AXIS_Y:  shy_d = rd_data;
            default: shz_d = rd_data;
          endcase
          if (axis_q == AXIS_Z) begin
            state_d = ST_DONE;
          end else begin
            axis_d  = axis_q + 2'd1;
            state_d = ST_GAP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        to_cnt_d = '0;
        state_d  = ST_REQ;
      end
      default: begin
        x_d     = shx_q;
        y_d     = shy_q;
        z_d     = shz_q;
        valid_d = 1'b1;
        count_d = count_q + CNT_W'(1);
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      axis_q    <= AXIS_X;
      to_cnt_q  <= '0;
      shx_q     <= '0;
      shy_q     <= '0;
      shz_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      axis_q    <= axis_d;
      to_cnt_q  <= to_cnt_d;
      shx_q     <= shx_d;
      shy_q     <= shy_d;
      shz_q     <= shz_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign rd_req       = (state_q == ST_REQ);
  assign rd_axis      = axis_q;
  assign x_out        = x_q;
  assign y_out        = y_q;
  assign z_out        = z_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;
  assign sample_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_sample_sequencer.sv
// ==== tb_accel_sample_sequencer : randomized + directed bench against a transaction-level model (rev 1.0) ====
`default_nettype none

module tb_accel_sample_sequencer;

  localparam int DW   = 16;
  localparam int SYNC = 2;
  localparam int TMO  = 5;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset, tick_clk, enable, rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_req, sample_valid, overrun, timeout_err;
  logic [1:0]    rd_axis;
  logic [DW-1:0] x_out, y_out, z_out;
  logic [CW-1:0] sample_count;

  accel_sample_sequencer #(
    .DATA_W(DW), .SYNC_STAGES(SYNC), .TIMEOUT(TMO), .TO_W(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .tick_clk(tick_clk), .enable(enable),
    .rd_req(rd_req), .rd_axis(rd_axis), .rd_ack(rd_ack), .rd_data(rd_data),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .sample_valid(sample_valid), .overrun(overrun), .timeout_err(timeout_err),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  bit          samp[$];              // tick_clk as sampled at each post-reset edge
  int          ph;                   // 0 idle, 1 requesting, 2 gap, 3 finishing
  int          m_axis, m_wait, m_cnt;
  logic [DW-1:0] m_sh[3];
  logic [DW-1:0] m_out[3];
  bit          m_sv, m_ov, m_te, m_valid;

  // A tick is a 0->1 between two consecutive real samples, seen SYNC edges after the 1.
  function automatic bit tick_detected();
    int k = samp.size();
    if (k < SYNC + 2) return 1'b0;
    return samp[k-SYNC-1] && !samp[k-SYNC-2];
  endfunction

  task automatic model_step();
    bit rise;
    if (reset) begin
      samp.delete();
      ph = 0; m_axis = 0; m_wait = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin m_sh[i] = '0; m_out[i] = '0; end
      m_sv = 0; m_ov = 0; m_te = 0; m_valid = 1;
      return;
    end
    rise = tick_detected();
    samp.push_back(tick_clk);
    m_sv = 0; m_te = 0;
    m_ov = rise && enable && (ph != 0);
    case (ph)
      0: if (rise && enable) begin ph = 1; m_axis = 0; m_wait = 0; end
      1: begin
        if (rd_ack) begin
          m_sh[m_axis] = rd_data;
          if (m_axis == 2) ph = 3;
          else begin m_axis++; ph = 2; end
        end else begin
          m_wait++;
          if (m_wait == TMO) begin m_te = 1; ph = 0; end
        end
      end
      2: begin m_wait = 0; ph = 1; end
      default: begin
        for (int i = 0; i < 3; i++) m_out[i] = m_sh[i];
        m_sv = 1; m_cnt = (m_cnt + 1) % (1 << CW); ph = 0;
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sensor responder ----------------
  bit            fixed_mode = 1;
  bit            spurious   = 0;
  int            lat_tbl[3];
  logic [DW-1:0] data_tbl[3];
  int            req_cycles = 0;
  int            lat = 1;

  task automatic sensor_drive();
    rd_ack = 1'b0;
    if (rd_req === 1'b1) begin
      req_cycles++;
      if (req_cycles == 1) lat = fixed_mode ? lat_tbl[rd_axis] : int'($urandom_range(1, TMO + 1));
      if (req_cycles == lat) begin
        rd_ack  = 1'b1;
        rd_data = fixed_mode ? data_tbl[rd_axis] : DW'($urandom);
      end
    end else begin
      req_cycles = 0;
      rd_data    = DW'($urandom);
      if (spurious && ($urandom_range(0, 7) == 0)) rd_ack = 1'b1;
    end
  endtask

  // ---------------- per-cycle compare + drive ----------------
  int sv_seen = 0, ov_seen = 0, te_seen = 0, req_seen = 0;

  task automatic cycle(input int n = 1);
    for (int c = 0; c < n; c++) begin
      if (m_valid) begin
        check("rd_req", rd_req, (ph == 1));
        if (ph == 1 && rd_req === 1'b1) check("rd_axis", rd_axis, m_axis);
        check("x_out", x_out, m_out[0]);
        check("y_out", y_out, m_out[1]);
        check("z_out", z_out, m_out[2]);
        check("sample_valid", sample_valid, m_sv);
        check("overrun", overrun, m_ov);
        check("timeout_err", timeout_err, m_te);
        check("sample_count", sample_count, m_cnt);
        sv_seen  += (sample_valid === 1'b1);
        ov_seen  += (overrun === 1'b1);
        te_seen  += (timeout_err === 1'b1);
        req_seen += (rd_req === 1'b1);
      end
      sensor_drive();
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic tick_pulse(input int hi, input int lo);
    tick_clk = 1'b1; cycle(hi);
    tick_clk = 1'b0; cycle(lo);
  endtask

  task automatic set_sensor(input int lx, input int ly, input int lz,
                            input logic [DW-1:0] dx, input logic [DW-1:0] dy, input logic [DW-1:0] dz);
    lat_tbl[0] = lx; lat_tbl[1] = ly; lat_tbl[2] = lz;
    data_tbl[0] = dx; data_tbl[1] = dy; data_tbl[2] = dz;
  endtask

  int sv0, ov0, te0, rq0;
  bit found;

  initial begin
    m_valid = 0;
    reset = 1'b1; tick_clk = 1'b0; enable = 1'b1; rd_ack = 1'b0; rd_data = '0;
    set_sensor(3, 3, 3, 16'h0011, 16'h0022, 16'h0033);
    @(negedge clk);
    cycle(3);
    check("reset_x", x_out, 0);
    check("reset_count", sample_count, 0);
    check("reset_rd_req", rd_req, 0);
    reset = 1'b0;
    cycle(8);

    // Basic sample: rd_req first high on the 4th negedge after tick_clk is driven
    sv0 = sv_seen;
    tick_clk = 1'b1;
    cycle(3);
    check("lat_req_low", rd_req, 0);
    cycle(1);
    check("lat_req_high", rd_req, 1);
    cycle(25);
    tick_clk = 1'b0;
    cycle(5);
    check("basic_x", x_out, 16'h0011);
    check("basic_y", y_out, 16'h0022);
    check("basic_z", z_out, 16'h0033);
    check("basic_count", sample_count, 1);
    check("basic_sv_once", sv_seen - sv0, 1);

    // Timeout on Y: outputs untouched, next tick restarts from X
    set_sensor(1, 99, 1, 16'h0aaa, 16'h0bbb, 16'h0ccc);
    sv0 = sv_seen; te0 = te_seen;
    tick_pulse(10, 20);
    check("tmo_pulse", te_seen - te0, 1);
    check("tmo_no_sv", sv_seen - sv0, 0);
    check("tmo_x_kept", x_out, 16'h0011);
    set_sensor(2, 2, 2, 16'h0101, 16'h0202, 16'h0303);
    tick_pulse(10, 20);
    check("tmo_restart_x", x_out, 16'h0101);
    check("tmo_restart_z", z_out, 16'h0303);

    // Overrun: second tick lands while Z is being waited on
    set_sensor(1, 1, 5, 16'h1111, 16'h2222, 16'h3333);
    sv0 = sv_seen; ov0 = ov_seen;
    tick_clk = 1'b1; cycle(2); tick_clk = 1'b0; cycle(3);
    tick_clk = 1'b1; cycle(3); tick_clk = 1'b0; cycle(30);
    check("ovr_once", ov_seen - ov0, 1);
    check("ovr_one_sample", sv_seen - sv0, 1);

    // Ack coinciding with the timeout limit is a good read
    set_sensor(5, 5, 5, 16'h5a5a, 16'h6b6b, 16'h7c7c);
    sv0 = sv_seen; te0 = te_seen;
    tick_pulse(10, 30);
    check("edge_ack_sv", sv_seen - sv0, 1);
    check("edge_ack_no_tmo", te_seen - te0, 0);
    check("edge_ack_y", y_out, 16'h6b6b);

    // enable low across three ticks
    enable = 1'b0; rq0 = req_seen; ov0 = ov_seen;
    for (int i = 0; i < 3; i++) tick_pulse(8, 8);
    check("dis_no_req", req_seen - rq0, 0);
    check("dis_no_ovr", ov_seen - ov0, 0);
    enable = 1'b1;

    // enable dropped mid-sequence
    set_sensor(3, 3, 3, 16'h0e01, 16'h0e02, 16'h0e03);
    sv0 = sv_seen;
    tick_clk = 1'b1; cycle(6); enable = 1'b0; tick_clk = 1'b0; cycle(25);
    enable = 1'b1;
    check("en_drop_completes", sv_seen - sv0, 1);
    check("en_drop_x", x_out, 16'h0e01);

    // reset asserted while requesting Y
    set_sensor(1, 5, 1, 16'h0f01, 16'h0f02, 16'h0f03);
    tick_clk = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1);
      if (rd_req === 1'b1 && rd_axis === 2'd1) found = 1;
    end
    check("find_y_req", found, 1);
    sv0 = sv_seen; te0 = te_seen;
    reset = 1'b1; cycle(1);
    check("rst_mid_req", rd_req, 0);
    check("rst_mid_x", x_out, 0);
    check("rst_mid_count", sample_count, 0);

    // tick_clk held high through reset release: no request until a fresh rise
    cycle(2); reset = 1'b0; rq0 = req_seen;
    cycle(20);
    check("rst_high_no_req", req_seen - rq0, 0);
    check("rst_no_sv", sv_seen - sv0, 0);
    check("rst_no_tmo", te_seen - te0, 0);
    tick_clk = 1'b0; cycle(5);
    tick_clk = 1'b1; cycle(10);
    check("rst_high_then_req", (req_seen - rq0) > 0, 1);
    tick_clk = 1'b0; cycle(10);

    // Counter wrap with CNT_W=4
    reset = 1'b1; cycle(2); reset = 1'b0; cycle(6);
    set_sensor(1, 1, 1, 16'h0001, 16'h0002, 16'h0003);
    for (int i = 0; i < 17; i++) tick_pulse(10, 10);
    cycle(10);
    check("wrap_count", sample_count, 1);

    // Randomized traffic
    fixed_mode = 0; spurious = 1;
    for (int i = 0; i < 80; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      tick_pulse($urandom_range(2, 30), $urandom_range(2, 30));
    end
    spurious = 0;
    cycle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
